// File: rtl/count_arb_pkg.sv
// count_arb_pkg: shared state encoding, counter width, clamp limit and limit clamp helper
package count_arb_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = 4'd10;
  function automatic logic [CNT_W-1:0] clamp_lim(input logic [CNT_W-1:0] l);
    return l > CNT_MAX ? CNT_MAX : l;
  endfunction
endpackage

// File: rtl/count_arb_if.sv
// count_arb_if: request/limit inputs and grant/Q/busy/done outputs of count_arb; pause exists only with COUNT_ARB_PAUSE_EN
interface count_arb_if;
  import count_arb_pkg::*;
  logic req0;
  logic req1;
  logic [CNT_W-1:0] lim0;
  logic [CNT_W-1:0] lim1;
  logic [1:0] grant;
  logic [CNT_W-1:0] Q;
  logic busy;
  logic done;
`ifdef COUNT_ARB_PAUSE_EN
  logic pause;
  modport master (output req0, req1, lim0, lim1, pause, input grant, Q, busy, done);
  modport slave (input req0, req1, lim0, lim1, pause, output grant, Q, busy, done);
`else
  modport master (output req0, req1, lim0, lim1, input grant, Q, busy, done);
  modport slave (input req0, req1, lim0, lim1, output grant, Q, busy, done);
`endif
endinterface

// File: rtl/count_core.sv
// count_core: shared counter; clk, res_n (async active-low), clr (sync clear, wins), en (increment), q (count)
module count_core
  import count_arb_pkg::*;
(
  input  logic             clk,
  input  logic             res_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] q
);
  always_ff @(posedge clk or negedge res_n)
    if (!res_n) q <= '0;
    else if (clr) q <= '0;
    else if (en) q <= q + 1'b1;
endmodule

// File: rtl/count_arb.sv
// count_arb: two-requester round-robin arbiter owning one counter that runs to a clamped limit.
// Ports: clk, res_n (async active-low), bus (count_arb_if.slave: req0/1, lim0/1 in; grant, Q, busy, done out).
// Optional macro COUNT_ARB_PAUSE_EN adds bus.pause, which freezes a run in progress.
module count_arb
  import count_arb_pkg::*;
(
  input  logic       clk,
  input  logic       res_n,
  count_arb_if.slave bus
);
  state_t state, state_n;
  logic ptr;
  logic [1:0] grant_r;
  logic [CNT_W-1:0] lim_r, q;
  logic win, owner_req, abort, fin, pause_i, clr, en;
`ifdef COUNT_ARB_PAUSE_EN
  assign pause_i = bus.pause;
`else
  assign pause_i = 1'b0;
`endif
  // ptr names the requester favoured on a tie: 0 = req0, 1 = req1
  always_comb begin
    win = (bus.req0 & bus.req1) ? ptr : bus.req1;
    owner_req = grant_r[1] ? bus.req1 : bus.req0;
    abort = state == RUN && !owner_req;
    fin = state == RUN && owner_req && !pause_i && q == lim_r;
    state_n = state == IDLE ? ((bus.req0 | bus.req1) ? RUN : IDLE) :
              state == RUN  ? (abort ? IDLE : fin ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk or negedge res_n)
    if (!res_n) begin
      state <= IDLE;
      ptr <= 1'b0;
      grant_r <= 2'b00;
      lim_r <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && state_n == RUN) begin
        grant_r <= win ? 2'b10 : 2'b01;
        lim_r <= clamp_lim(win ? bus.lim1 : bus.lim0);
      end else if (state == RUN && state_n != RUN) begin
        grant_r <= 2'b00;
        ptr <= ~grant_r[1];
      end
    end
  // Q clears outside RUN so the grant edge starts from 0 and the cycle after DONE shows 0
  always_comb begin
    clr = state != RUN || abort;
    en = state == RUN && owner_req && !pause_i && q != lim_r;
    bus.grant = grant_r;
    bus.Q = q;
    bus.busy = state == RUN;
    bus.done = state == DONE;
  end
  count_core u_core (.clk(clk), .res_n(res_n), .clr(clr), .en(en), .q(q));
endmodule
